inst_rom_loader: RTL

- Instruction memory that sits directly upstream of the openmips core.
- Accepts a program image as a byte stream over a valid/ready load port and assembles it big-endian into 32-bit words.
- After the image is complete, serves fetches on the core's rom_ce/rom_addr/rom_data interface.
- Holds the core in reset until a complete image is loaded.

---
 rtl/inst_rom_loader_pkg.sv | 16 +
 rtl/inst_rom_loader_if.sv | 24 ++
 rtl/inst_rom_loader_mem.sv | 23 ++
 rtl/inst_rom_loader.sv | 109 ++++++++++
 4 files changed

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM loader.
package inst_rom_loader_pkg;

    typedef enum logic [1:0] {
        LdIdle = 2'b00,
        LdLoad = 2'b01,
        LdRun  = 2'b10,
        LdErr  = 2'b11
    } ld_state_e;

    localparam int unsigned InstBusW  = 32;
    localparam logic [InstBusW-1:0] ZeroWord = '0;
    // Level that holds openmips in reset.
    localparam logic RstEnable = 1'b1;

endpackage

// File: rtl/inst_rom_loader_if.sv
// Byte-stream load port plus the core's instruction fetch port.
interface inst_rom_loader_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              ld_valid_i;
    logic [7:0]        ld_data_i;
    logic              ld_last_i;
    logic              ld_ready_o;
    logic              rom_ce_i;
    logic [ADDR_W-1:0] rom_addr_i;
    logic [31:0]       rom_data_o;

    modport master (
        output ld_valid_i, ld_data_i, ld_last_i, rom_ce_i, rom_addr_i,
        input  ld_ready_o, rom_data_o
    );

    modport slave (
        input  ld_valid_i, ld_data_i, ld_last_i, rom_ce_i, rom_addr_i,
        output ld_ready_o, rom_data_o
    );

endinterface

// File: rtl/inst_rom_loader_mem.sv
// Word array with one synchronous write port and one asynchronous read port.
module inst_rom_loader_mem #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_loader.sv
// Loads a big-endian byte image into instruction memory, then serves openmips fetches.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_loader_if.slave      bus,
    output logic                  cpu_rst_o,
    output logic                  load_done_o,
    output logic                  load_err_o,
    output logic [DEPTH_LOG2:0]   word_cnt_o
);

    localparam logic [DEPTH_LOG2-1:0] WptrOne = 1;
    localparam logic [DEPTH_LOG2-1:0] WptrMax = '1;
    localparam logic [DEPTH_LOG2:0]   CntOne  = 1;

    ld_state_e             state_q, state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           buf_q, buf_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;

    logic                  accept;
    logic                  word_done;
    logic                  we;
    logic [31:0]           wdata;
    logic [DEPTH_LOG2-1:0] ridx;
    logic [31:0]           rdata;
    logic                  unused_addr_lsb;

    assign bus.ld_ready_o = (state_q == LdIdle) || (state_q == LdLoad);
    assign accept         = bus.ld_valid_i && bus.ld_ready_o;
    assign word_done      = (byte_idx_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= LdIdle;
            byte_idx_q <= 2'd0;
            buf_q      <= '0;
            wptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            buf_q      <= buf_d;
            wptr_q     <= wptr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        buf_d      = buf_q;
        wptr_d     = wptr_q;
        cnt_d      = cnt_q;
        we         = 1'b0;
        wdata      = {buf_q, bus.ld_data_i};
        if (accept) begin
            buf_d      = {buf_q[15:0], bus.ld_data_i};
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = LdLoad;
            if (word_done) begin
                we     = 1'b1;
                wptr_d = wptr_q + WptrOne;
                cnt_d  = cnt_q + CntOne;
            end
            // A last byte that does not close a word leaves a partial word, which is dropped.
            if (bus.ld_last_i) begin
                state_d = word_done ? LdRun : LdErr;
            end else if (word_done && (wptr_q == WptrMax)) begin
                state_d = LdErr;
            end
        end
    end

    assign cpu_rst_o   = (state_q == LdRun) ? ~RstEnable : RstEnable;
    assign load_done_o = (state_q == LdRun);
    assign load_err_o  = (state_q == LdErr);
    assign word_cnt_o  = cnt_q;

    inst_rom_loader_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (ridx),
        .rdata (rdata)
    );

    assign ridx            = bus.rom_addr_i[DEPTH_LOG2+1:2];
    assign unused_addr_lsb = ^bus.rom_addr_i[1:0];

    // Stale words from a discarded load stay hidden behind the word count.
    always_comb begin
        bus.rom_data_o = ZeroWord;
        if (bus.rom_ce_i && (state_q == LdRun) && ({1'b0, ridx} < cnt_q) &&
            (bus.rom_addr_i[ADDR_W-1:DEPTH_LOG2+2] == '0)) begin
            bus.rom_data_o = rdata;
        end
    end

endmodule
